shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_if.sv | 22 ++
 rtl/shift_add_multiplier.sv | 108 ++++++++++
 tb/tb_shift_add_multiplier.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle between a requester and the shift-and-add multiplier.
// The master issues operands; the slave reports progress and the product.
interface shift_add_multiplier_if #(
    parameter int N = 4
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier, one partial product per clock.
// The only arithmetic element is an N-bit ripple-carry adder.
module adder_n_bit #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign c_out = c[N];
endmodule

module shift_add_multiplier #(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  m;
    logic [N-1:0]  acc;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          c_out;
    logic          last;

    assign addend = q[0] ? m : '0;
    assign last   = (cnt == CW'(N - 1));

    adder_n_bit #(.N(N)) u_adder (
        .x     (acc),
        .y     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Carry-out is shifted into ACC so the product stays exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (state == S_IDLE && bus.start) begin
            m   <= bus.a;
            q   <= bus.b;
            acc <= '0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            {acc, q} <= {c_out, sum, q[N-1:1]};
            cnt      <= cnt + CW'(1);
        end
    end

    assign bus.product = {acc, q};
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier at N=4 and N=8.
// Expected products come from plain integer multiplication.
module tb_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    int   overlap = 0;

    shift_add_multiplier_if #(.N(4)) bus4 ();
    shift_add_multiplier_if #(.N(8)) bus8 ();

    shift_add_multiplier #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    shift_add_multiplier #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic mul4(input logic [3:0] x, input logic [3:0] y,
                        input string tag);
        int nb;
        bit seen;
        int e;
        e = int'(x) * int'(y);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a = x;
        bus4.b = y;
        @(negedge clk);
        bus4.start = 1'b0;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus4.busy && bus4.done) overlap++;
            if (bus4.done) seen = 1;
            else begin
                if (bus4.busy) nb++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " busy_cycles"}, 64'(nb), 64'd4);
        check({tag, " product"}, 64'(bus4.product), 64'(e));
        @(negedge clk);
        check({tag, " done_width"}, 64'(bus4.done), 64'd0);
        check({tag, " hold"}, 64'(bus4.product), 64'(e));
    endtask

    task automatic mul8(input logic [7:0] x, input logic [7:0] y,
                        input string tag);
        int nb;
        bit seen;
        int e;
        e = int'(x) * int'(y);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = x;
        bus8.b = y;
        @(negedge clk);
        bus8.start = 1'b0;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus8.busy && bus8.done) overlap++;
            if (bus8.done) seen = 1;
            else begin
                if (bus8.busy) nb++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " busy_cycles"}, 64'(nb), 64'd8);
        check({tag, " product"}, 64'(bus8.product), 64'(e));
        @(negedge clk);
        check({tag, " hold"}, 64'(bus8.product), 64'(e));
    endtask

    initial begin
        int pulses;
        int idx[$];
        bus4.start = 0; bus4.a = 0; bus4.b = 0;
        bus8.start = 0; bus8.a = 0; bus8.b = 0;

        repeat (2) @(negedge clk);
        check("rst busy", 64'(bus4.busy), 64'd0);
        check("rst done", 64'(bus4.done), 64'd0);
        check("rst product", 64'(bus4.product), 64'd0);
        check("rst product8", 64'(bus8.product), 64'd0);
        rst_n = 1'b1;

        mul4(4'd3, 4'd5, "3x5");
        mul4(4'd15, 4'd15, "15x15");
        mul4(4'd0, 4'd9, "0x9");
        mul4(4'd9, 4'd0, "9x0");

        // start held high: back-to-back results every N+2 cycles
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a = 4'd7;
        bus4.b = 4'd6;
        pulses = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 2) bus4.a = 4'd1;
            if (k == 4) bus4.a = 4'd7;
            if (bus4.busy && bus4.done) overlap++;
            if (bus4.done) begin
                pulses++;
                idx.push_back(k);
                check("held product", 64'(bus4.product), 64'd42);
            end
        end
        bus4.start = 1'b0;
        check("held pulses", 64'(pulses), 64'd3);
        if (idx.size() == 3) begin
            check("held first", 64'(idx[0]), 64'd5);
            check("held gap1", 64'(idx[1] - idx[0]), 64'd6);
            check("held gap2", 64'(idx[2] - idx[1]), 64'd6);
        end
        repeat (2) @(negedge clk);

        // asynchronous abort in RUN
        bus4.start = 1'b1;
        bus4.a = 4'd13;
        bus4.b = 4'd11;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(bus4.busy), 64'd0);
        check("abort done", 64'(bus4.done), 64'd0);
        check("abort product", 64'(bus4.product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mul4(4'd2, 4'd3, "after_rst");

        for (int i = 0; i < 50; i++)
            mul4(4'($urandom), 4'($urandom), "rand4");

        mul8(8'd255, 8'd255, "255x255");
        for (int i = 0; i < 1000; i++)
            mul8(8'($urandom), 8'($urandom), "rand8");

        check("busy_done_overlap", 64'(overlap), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
